dsp_output_stage: RTL and testbench
===================================

// Module: dsp_output_stage
// PURPOSE
// - Consumer end of the DSP-slice ALU bus. Registers ALU result/carry/mult-sign into the P register.
// - Drives the PCOUT cascade.
// - Runs pattern / inverted-pattern detection, overflow/underflow tracking and optional pattern auto-reset.
// - Sits directly after the ALU; its P output feeds back as the slice accumulator operand.
// PARAMETERS
// - WIDTH              48               datapath width, equal to the ALU width
// - PREG               1                1 = P stage registered; 0 = combinational pass-through
// - USE_PATTERN_DETECT "NO_PATDET"      "PATDET" enables all detect/overflow logic; otherwise flags tie to 0
// - PATTERN            {WIDTH{1'b0}}    static pattern
// - MASK               {WIDTH{1'b1}}    static mask; a 1 bit is ignored in the compare
// - SEL_PATTERN        "PATTERN"        "PATTERN" uses the parameter, "C" uses the C port
// - SEL_MASK           "MASK"           "MASK" uses the parameter, "C" uses the C port
// - AUTORESET_PATDET   "NO_RESET"       "NO_RESET" | "RESET_MATCH" | "RESET_NOT_MATCH"
// PORTS
// - CLK             in   1      slice clock; all state changes on rising edge
// - RSTP            in   1      synchronous, active-high reset of all P-stage state
// - CEP             in   1      clock enable for P, CARRYOUT, MULTSIGNOUT, flags and past flags
// - ALU_OUT         in   WIDTH  ALU result
// - ALU_COUT        in   1      ALU carry out
// - ALU_MULTSIGN    in   1      ALU multiply_sign_out
// - C               in   WIDTH  C operand; selectable as dynamic pattern or mask
// - P               out  WIDTH  slice result
// - PCOUT           out  WIDTH  cascade out; always identical to P
// - CARRYOUT        out  1      registered ALU_COUT
// - MULTSIGNOUT     out  1      registered ALU_MULTSIGN
// - PATTERNDETECT   out  1      P matches pattern under mask
// - PATTERNBDETECT  out  1      P matches ~pattern under mask
// - OVERFLOW        out  1      detect overflow (see below)
// - UNDERFLOW       out  1      detect underflow (see below)
// BEHAVIOUR
// - Clock/reset: one clock CLK; reset RSTP is synchronous and active-high.
// - Detect function on value V: pd(V) = &(~(V^pat) | msk); pbd(V) = &((V^pat) | msk).
//   - pat/msk are taken from the parameter or C, per SEL_PATTERN / SEL_MASK.
//   - When USE_PATTERN_DETECT != "PATDET": pd = pbd = 0, and OVERFLOW/UNDERFLOW = 0.
// - PREG=1, priority at each rising CLK edge:
//   1. RSTP=1: P, CARRYOUT, MULTSIGNOUT, PATTERNDETECT, PATTERNBDETECT, pd_past and pbd_past all load 0.
//      Reset wins over CEP and over auto-reset.
//   2. CEP=1 and auto-reset condition true: P<=0, CARRYOUT<=0, MULTSIGNOUT<=0, flags <= pd(0)/pbd(0).
//      - RESET_MATCH condition: PATTERNDETECT=1.
//      - RESET_NOT_MATCH condition: PATTERNDETECT=0 and pd_past=1.
//   3. CEP=1 otherwise: P<=ALU_OUT, CARRYOUT<=ALU_COUT, MULTSIGNOUT<=ALU_MULTSIGN,
//      PATTERNDETECT<=pd(ALU_OUT), PATTERNBDETECT<=pbd(ALU_OUT).
//   4. CEP=0: every register holds.
//   - In cases 2 and 3: pd_past<=PATTERNDETECT and pbd_past<=PATTERNBDETECT (old values).
// - PREG=1 latency: 1 cycle, ALU inputs to P and flags.
// - OVERFLOW  = ~PATTERNDETECT & ~PATTERNBDETECT & pd_past (combinational from registers).
// - UNDERFLOW = ~PATTERNDETECT & ~PATTERNBDETECT & pbd_past.
// - PREG=0:
//   - P = ALU_OUT, CARRYOUT = ALU_COUT, MULTSIGNOUT = ALU_MULTSIGN.
//   - Flags = pd/pbd(ALU_OUT), combinational.
//   - OVERFLOW = UNDERFLOW = 0; RSTP/CEP/auto-reset have no effect.
// - Mid-operation RSTP clears the past flags, so OVERFLOW/UNDERFLOW cannot assert on the cycle after reset.
// - No wrap-around handling here; arithmetic wrap is the ALU's, and the stage stores WIDTH bits unmodified.
// STRUCTURE
// - Shared package dsp_pkg: string localparams for all parameter values.
//   - Values: NONE/PATDET/NO_PATDET, SEL_* selectors, AUTORESET_* modes.
//   - Also WIDTH default 48 shared with the ALU.
// - One sub-module dsp_pattern_detect (combinational): inputs V, pat, msk; outputs pd, pbd.
//   - Instantiated once, on the value about to be loaded into P.
// - Top holds: P register, past-flag registers, auto-reset control, PREG generate bypass.
// TESTING
// 1. Reset: RSTP=1 with CEP=1, ALU_OUT=48'h1234 -> next edge P=0, CARRYOUT=0, all flags 0, OVERFLOW=0.
// 2. Latency/enable: CEP=1, ALU_OUT=48'hABCD -> P=48'hABCD one edge later.
//    Then CEP=0, ALU_OUT=48'h1 -> P stays 48'hABCD.
// 3. Detect: PATDET, PATTERN=0, MASK=48'hFFFF_FFFF_FF00.
//    - ALU_OUT=48'h00 -> PATTERNDETECT=1.
//    - ALU_OUT=48'hFF -> PATTERNBDETECT=1.
//    - ALU_OUT=48'h01 -> both 0.
// 4. Overflow: load 48'h00 (PD=1), then 48'h80 -> PD=PBD=0, OVERFLOW=1 for that cycle.
//    Next load 48'h80 again -> OVERFLOW=0.
// 5. Auto-reset: RESET_MATCH, load 48'h00 (PD=1) -> next CEP edge P=0 regardless of ALU_OUT=48'h55.
//    Same with CEP=0 -> P holds.
// 6. SEL_PATTERN="C", C=48'h5 -> ALU_OUT=48'h5 -> PATTERNDETECT=1.
//    PREG=0 -> P tracks ALU_OUT in same cycle.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP slice: default datapath width and the string
// values accepted by the output-stage configuration parameters.
package dsp_pkg;

    localparam int DSP_WIDTH = 48;

    localparam string PATDET_NONE = "NONE";
    localparam string PATDET_ON   = "PATDET";
    localparam string PATDET_OFF  = "NO_PATDET";

    localparam string SEL_PATTERN_PARAM = "PATTERN";
    localparam string SEL_MASK_PARAM    = "MASK";
    localparam string SEL_C             = "C";

    localparam string AUTORESET_NONE      = "NO_RESET";
    localparam string AUTORESET_MATCH     = "RESET_MATCH";
    localparam string AUTORESET_NOT_MATCH = "RESET_NOT_MATCH";

    typedef enum logic [1:0] {
        AR_NONE,
        AR_MATCH,
        AR_NOT_MATCH
    } autoreset_e;

endpackage

// File: rtl/dsp_pattern_detect.sv
// Masked pattern compare: pd when the value equals the pattern, pbd when it
// equals the inverted pattern; mask bits set to 1 are don't-care.
module dsp_pattern_detect #(
    parameter int WIDTH = 48
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] pat_i,
    input  logic [WIDTH-1:0] msk_i,
    output logic             pd_o,
    output logic             pbd_o
);

    assign pd_o  = &(~(value_i ^ pat_i) | msk_i);
    assign pbd_o = &((value_i ^ pat_i) | msk_i);

endmodule

// File: rtl/dsp_output_stage.sv
// P stage of the DSP slice: result/carry/sign registers, pattern detect flags,
// overflow/underflow derived from past flags, and optional pattern auto-reset.
module dsp_output_stage
    import dsp_pkg::*;
#(
    parameter int               WIDTH              = DSP_WIDTH,
    parameter int               PREG               = 1,
    parameter string            USE_PATTERN_DETECT = PATDET_OFF,
    parameter logic [WIDTH-1:0] PATTERN            = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] MASK               = {WIDTH{1'b1}},
    parameter string            SEL_PATTERN        = SEL_PATTERN_PARAM,
    parameter string            SEL_MASK           = SEL_MASK_PARAM,
    parameter string            AUTORESET_PATDET   = AUTORESET_NONE
) (
    input  logic             CLK,
    input  logic             RSTP,
    input  logic             CEP,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_COUT,
    input  logic             ALU_MULTSIGN,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] PCOUT,
    output logic             CARRYOUT,
    output logic             MULTSIGNOUT,
    output logic             PATTERNDETECT,
    output logic             PATTERNBDETECT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam bit DetectOn = (USE_PATTERN_DETECT == PATDET_ON);
    localparam bit PatFromC = (SEL_PATTERN == SEL_C);
    localparam bit MskFromC = (SEL_MASK == SEL_C);
    localparam autoreset_e ArMode =
        (AUTORESET_PATDET == AUTORESET_MATCH)     ? AR_MATCH     :
        (AUTORESET_PATDET == AUTORESET_NOT_MATCH) ? AR_NOT_MATCH : AR_NONE;

    logic [WIDTH-1:0] patSel;
    logic [WIDTH-1:0] mskSel;
    logic [WIDTH-1:0] loadValue;
    logic             pdRaw;
    logic             pbdRaw;
    logic             pdNext;
    logic             pbdNext;
    logic             unusedC;

    assign patSel  = PatFromC ? C : PATTERN;
    assign mskSel  = MskFromC ? C : MASK;
    assign unusedC = ^C;

    // Single detector looks at whatever P is about to become (ALU result or auto-reset zero).
    dsp_pattern_detect #(.WIDTH(WIDTH)) uDetect (
        .value_i (loadValue),
        .pat_i   (patSel),
        .msk_i   (mskSel),
        .pd_o    (pdRaw),
        .pbd_o   (pbdRaw)
    );

    assign pdNext  = DetectOn & pdRaw;
    assign pbdNext = DetectOn & pbdRaw;
    assign PCOUT   = P;

    generate
        if (PREG == 1) begin : gReg
            logic [WIDTH-1:0] pQ;
            logic [WIDTH-1:0] pD;
            logic             carryQ, carryD;
            logic             signQ, signD;
            logic             pdQ, pbdQ;
            logic             pdPastQ, pbdPastQ;
            logic             autoReset;

            always_comb begin
                autoReset = 1'b0;
                if (ArMode == AR_MATCH) begin
                    autoReset = pdQ;
                end else if (ArMode == AR_NOT_MATCH) begin
                    autoReset = !pdQ && pdPastQ;
                end
                pD     = autoReset ? '0   : ALU_OUT;
                carryD = autoReset ? 1'b0 : ALU_COUT;
                signD  = autoReset ? 1'b0 : ALU_MULTSIGN;
            end

            assign loadValue = pD;

            // Reset beats enable; past flags capture the flags being replaced.
            always_ff @(posedge CLK) begin
                if (RSTP) begin
                    pQ       <= '0;
                    carryQ   <= 1'b0;
                    signQ    <= 1'b0;
                    pdQ      <= 1'b0;
                    pbdQ     <= 1'b0;
                    pdPastQ  <= 1'b0;
                    pbdPastQ <= 1'b0;
                end else if (CEP) begin
                    pQ       <= pD;
                    carryQ   <= carryD;
                    signQ    <= signD;
                    pdQ      <= pdNext;
                    pbdQ     <= pbdNext;
                    pdPastQ  <= pdQ;
                    pbdPastQ <= pbdQ;
                end
            end

            assign P              = pQ;
            assign CARRYOUT       = carryQ;
            assign MULTSIGNOUT    = signQ;
            assign PATTERNDETECT  = pdQ;
            assign PATTERNBDETECT = pbdQ;
            assign OVERFLOW       = ~pdQ & ~pbdQ & pdPastQ;
            assign UNDERFLOW      = ~pdQ & ~pbdQ & pbdPastQ;
        end else begin : gBypass
            logic unusedCtrl;
            assign unusedCtrl = ^{CLK, RSTP, CEP};

            assign loadValue      = ALU_OUT;
            assign P              = ALU_OUT;
            assign CARRYOUT       = ALU_COUT;
            assign MULTSIGNOUT    = ALU_MULTSIGN;
            assign PATTERNDETECT  = pdNext;
            assign PATTERNBDETECT = pbdNext;
            assign OVERFLOW       = 1'b0;
            assign UNDERFLOW      = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_output_stage.sv
// Directed scoreboard bench for dsp_output_stage across four configurations:
// registered with detect, registered with RESET_MATCH, pass-through with C pattern, defaults.
module tb_dsp_output_stage;
    import dsp_pkg::*;

    localparam int               W       = 48;
    localparam logic [W-1:0]     TB_MASK = 48'hFFFF_FFFF_FF00;

    typedef struct {
        int           unit;
        string        tag;
        logic [W-1:0] p;
        logic         cout;
        logic         ms;
        logic         pd;
        logic         pbd;
        logic         ov;
        logic         un;
    } expect_t;

    expect_t sb[$];
    int errors = 0;
    int checks = 0;

    logic         clk = 1'b0;
    logic         rstp, cep, aluCout, aluMultsign;
    logic [W-1:0] aluOut, cIn;

    logic [W-1:0] pA, pcoutA, pB, pcoutB, pC, pcoutC, pD, pcoutD;
    logic coutA, msA, pdA, pbdA, ovA, unA;
    logic coutB, msB, pdB, pbdB, ovB, unB;
    logic coutC, msC, pdC, pbdC, ovC, unC;
    logic coutD, msD, pdD, pbdD, ovD, unD;

    always #5 clk = ~clk;

    dsp_output_stage #(.WIDTH(W), .PREG(1), .USE_PATTERN_DETECT("PATDET"),
        .PATTERN(48'h0), .MASK(TB_MASK), .SEL_PATTERN("PATTERN"), .SEL_MASK("MASK"),
        .AUTORESET_PATDET("NO_RESET")) uA (
        .CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(aluOut), .ALU_COUT(aluCout),
        .ALU_MULTSIGN(aluMultsign), .C(cIn), .P(pA), .PCOUT(pcoutA), .CARRYOUT(coutA),
        .MULTSIGNOUT(msA), .PATTERNDETECT(pdA), .PATTERNBDETECT(pbdA),
        .OVERFLOW(ovA), .UNDERFLOW(unA));

    dsp_output_stage #(.WIDTH(W), .PREG(1), .USE_PATTERN_DETECT("PATDET"),
        .PATTERN(48'h55), .MASK(TB_MASK), .SEL_PATTERN("PATTERN"), .SEL_MASK("MASK"),
        .AUTORESET_PATDET("RESET_MATCH")) uB (
        .CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(aluOut), .ALU_COUT(aluCout),
        .ALU_MULTSIGN(aluMultsign), .C(cIn), .P(pB), .PCOUT(pcoutB), .CARRYOUT(coutB),
        .MULTSIGNOUT(msB), .PATTERNDETECT(pdB), .PATTERNBDETECT(pbdB),
        .OVERFLOW(ovB), .UNDERFLOW(unB));

    dsp_output_stage #(.WIDTH(W), .PREG(0), .USE_PATTERN_DETECT("PATDET"),
        .PATTERN(48'h0), .MASK(TB_MASK), .SEL_PATTERN("C"), .SEL_MASK("MASK"),
        .AUTORESET_PATDET("NO_RESET")) uC (
        .CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(aluOut), .ALU_COUT(aluCout),
        .ALU_MULTSIGN(aluMultsign), .C(cIn), .P(pC), .PCOUT(pcoutC), .CARRYOUT(coutC),
        .MULTSIGNOUT(msC), .PATTERNDETECT(pdC), .PATTERNBDETECT(pbdC),
        .OVERFLOW(ovC), .UNDERFLOW(unC));

    dsp_output_stage uD (
        .CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(aluOut), .ALU_COUT(aluCout),
        .ALU_MULTSIGN(aluMultsign), .C(cIn), .P(pD), .PCOUT(pcoutD), .CARRYOUT(coutD),
        .MULTSIGNOUT(msD), .PATTERNDETECT(pdD), .PATTERNBDETECT(pbdD),
        .OVERFLOW(ovD), .UNDERFLOW(unD));

    task automatic checkWord(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with the unit it names.
    task automatic checkOutput();
        expect_t      e;
        logic [W-1:0] oP, oPc;
        logic         oCo, oMs, oPd, oPbd, oOv, oUn;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        case (e.unit)
            0:       begin oP = pA; oPc = pcoutA; oCo = coutA; oMs = msA; oPd = pdA; oPbd = pbdA; oOv = ovA; oUn = unA; end
            1:       begin oP = pB; oPc = pcoutB; oCo = coutB; oMs = msB; oPd = pdB; oPbd = pbdB; oOv = ovB; oUn = unB; end
            default: begin oP = pC; oPc = pcoutC; oCo = coutC; oMs = msC; oPd = pdC; oPbd = pbdC; oOv = ovC; oUn = unC; end
        endcase
        checkWord({e.tag, ".P"}, oP, e.p);
        checkWord({e.tag, ".PCOUT"}, oPc, e.p);
        checkBit({e.tag, ".CARRYOUT"}, oCo, e.cout);
        checkBit({e.tag, ".MULTSIGNOUT"}, oMs, e.ms);
        checkBit({e.tag, ".PATTERNDETECT"}, oPd, e.pd);
        checkBit({e.tag, ".PATTERNBDETECT"}, oPbd, e.pbd);
        checkBit({e.tag, ".OVERFLOW"}, oOv, e.ov);
        checkBit({e.tag, ".UNDERFLOW"}, oUn, e.un);
    endtask

    // Pushes the expectation, drives the inputs, then samples 1ns after the edge
    // (or 1ns after the drive for the pass-through unit).
    task automatic applyStimulus(input int unit, input string tag, input logic rst, input logic en,
                                 input logic [W-1:0] alu, input logic co, input logic msg,
                                 input logic [W-1:0] c, input bit clocked,
                                 input logic [W-1:0] eP, input logic eCo, input logic eMs,
                                 input logic ePd, input logic ePbd, input logic eOv, input logic eUn);
        expect_t e;
        e.unit = unit; e.tag = tag; e.p = eP; e.cout = eCo; e.ms = eMs;
        e.pd = ePd; e.pbd = ePbd; e.ov = eOv; e.un = eUn;
        sb.push_back(e);
        rstp = rst; cep = en; aluOut = alu; aluCout = co; aluMultsign = msg; cIn = c;
        if (clocked) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        checkOutput();
    endtask

    initial begin
        rstp = 1'b1; cep = 1'b1; aluOut = '0; aluCout = 1'b0; aluMultsign = 1'b0; cIn = '0;

        // Unit A: mask leaves only the low byte compared against pattern 0.
        //           unit tag         rst   cep   alu        co    ms    c      clk  P          co    ms    pd    pbd   ov    un
        applyStimulus(0, "aReset",   1'b1, 1'b1, 48'h1234,  1'b1, 1'b1, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aLoad",    1'b0, 1'b1, 48'hABCD,  1'b1, 1'b1, 48'h0, 1, 48'hABCD,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aHold",    1'b0, 1'b0, 48'h1,     1'b0, 1'b0, 48'h0, 1, 48'hABCD,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aPd",      1'b0, 1'b1, 48'h00,    1'b0, 1'b0, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkBit("dDefaultPd", pdD, 1'b0);
        checkBit("dDefaultOv", ovD, 1'b0);
        checkWord("dDefaultP", pD, 48'h0);
        applyStimulus(0, "aPbd",     1'b0, 1'b1, 48'hFF,    1'b1, 1'b0, 48'h0, 1, 48'hFF,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkBit("dDefaultPbd", pbdD, 1'b0);
        applyStimulus(0, "aUnder",   1'b0, 1'b1, 48'h01,    1'b0, 1'b1, 48'h0, 1, 48'h01,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, "aPd2",     1'b0, 1'b1, 48'h00,    1'b0, 1'b0, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aOver",    1'b0, 1'b1, 48'h80,    1'b0, 1'b0, 48'h0, 1, 48'h80,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, "aOverEnd", 1'b0, 1'b1, 48'h80,    1'b0, 1'b0, 48'h0, 1, 48'h80,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aPd3",     1'b0, 1'b1, 48'h00,    1'b0, 1'b0, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aOver2",   1'b0, 1'b1, 48'h80,    1'b0, 1'b0, 48'h0, 1, 48'h80,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, "aMidRst",  1'b1, 1'b1, 48'h80,    1'b1, 1'b1, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "aPostRst", 1'b0, 1'b1, 48'h80,    1'b0, 1'b0, 48'h0, 1, 48'h80,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unit B: pattern 0x55 in the low byte, RESET_MATCH auto-reset.
        applyStimulus(1, "bReset",   1'b1, 1'b1, 48'h1234,  1'b1, 1'b1, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, "bMatch",   1'b0, 1'b1, 48'h55,    1'b1, 1'b1, 48'h0, 1, 48'h55,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, "bHold",    1'b0, 1'b0, 48'hAA,    1'b0, 1'b0, 48'h0, 1, 48'h55,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, "bAutoRst", 1'b0, 1'b1, 48'hAA,    1'b1, 1'b1, 48'h0, 1, 48'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, "bResume",  1'b0, 1'b1, 48'hAA,    1'b1, 1'b1, 48'h0, 1, 48'hAA,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Unit C: pass-through, pattern taken from C; reset/enable ignored.
        applyStimulus(2, "cMatch",   1'b0, 1'b1, 48'h5,     1'b1, 1'b0, 48'h5, 0, 48'h5,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, "cInvert",  1'b0, 1'b1, 48'hFA,    1'b0, 1'b1, 48'h5, 0, 48'hFA,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2, "cRstIgn",  1'b1, 1'b1, 48'h1234,  1'b1, 1'b1, 48'h5, 1, 48'h1234,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, "cCepIgn",  1'b0, 1'b0, 48'h0,     1'b0, 1'b0, 48'h0, 0, 48'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
